bit_sync_filt: RTL and testbench

Multi-channel level synchronizer with a configurable-depth flop chain, a per-channel glitch filter and optional edge-pulse outputs. It is the successor of the plain multi-flop bit synchronizer. It sits at every asynchronous single-bit or independent-bit input crossing into a clock domain, such as FIFO status flags, external strobes and button/line inputs. Each channel is independent, and no bus coherency is implied.

---
 rtl/bit_sync_pkg.sv | 16 +
 rtl/bit_sync_filt_ch.sv | 83 ++++++++
 rtl/bit_sync_filt.sv | 65 ++++++
 tb/tb_bit_sync_filt.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_sync_pkg.sv
// bit_sync_pkg: shared constants and helpers for the bit_sync_filt slice.
//   cnt_width()      : filter counter width, clog2(n) with a floor of 1 bit.
//   MIN_NUM_STAGES   : smallest legal synchronizer depth.
//   MIN_FILTER_CNT   : smallest legal filter length.
package bit_sync_pkg;

    localparam int unsigned MIN_NUM_STAGES = 2;
    localparam int unsigned MIN_FILTER_CNT = 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_sync_filt_ch.sv
// bit_sync_filt_ch: single-channel glitch filter with optional edge pulses.
//   clk   : destination-domain clock
//   rst   : synchronous, active-high reset
//   raw   : synchronized (unfiltered) level from the flop chain
//   sync  : filtered level; follows raw once it has differed for FILTER_CNT cycles
//   rise  : one-cycle pulse when sync goes 0->1 (only with BIT_SYNC_FILT_EDGE_EN)
//   fall  : one-cycle pulse when sync goes 1->0 (only with BIT_SYNC_FILT_EDGE_EN)
// Build option: BIT_SYNC_FILT_EDGE_EN enables the rise/fall registers; when
// undefined both outputs are constant 0.
module bit_sync_filt_ch
    import bit_sync_pkg::*;
#(
    parameter int unsigned FILTER_CNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW      = cnt_width(FILTER_CNT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CNT - 1);

    logic          filt;
    logic          filt_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Any return of raw to the held level restarts the count; the counter
    // tops out at CNT_MAX, where the new level is accepted.
    always_comb begin
        filt_nxt = filt;
        cnt_nxt  = cnt;
        if (raw == filt) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
            filt_nxt = raw;
            cnt_nxt  = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            filt <= filt_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign sync = filt;

`ifdef BIT_SYNC_FILT_EDGE_EN
    logic accept;
    logic rise_q;
    logic fall_q;

    // Pulses are registered on the same edge that updates filt.
    assign accept = (raw != filt) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept &  raw;
            fall_q <= accept & ~raw;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/bit_sync_filt.sv
// bit_sync_filt: multi-channel level synchronizer with glitch filter.
//   clk   : destination-domain clock
//   rst   : synchronous, active-high reset
//   async : BUS_WIDTH independent asynchronous inputs
//   sync  : synchronized, filtered level per channel
//   rise  : one-cycle pulse per channel on sync 0->1
//   fall  : one-cycle pulse per channel on sync 1->0
// Build option: BIT_SYNC_FILT_EDGE_EN enables rise/fall; when undefined they
// are tied to 0. sync timing is the same in both builds.
// Latency: NUM_STAGES-1+FILTER_CNT edges from the stage0 sampling edge.
module bit_sync_filt
    import bit_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 4,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned FILTER_CNT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] async,
    output logic [BUS_WIDTH-1:0] sync,
    output logic [BUS_WIDTH-1:0] rise,
    output logic [BUS_WIDTH-1:0] fall
);

    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("bit_sync_filt: BUS_WIDTH must be >= 1");
    end
    if (NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_stages
        $error("bit_sync_filt: NUM_STAGES below minimum");
    end
    if (FILTER_CNT < MIN_FILTER_CNT) begin : g_bad_filter
        $error("bit_sync_filt: FILTER_CNT below minimum");
    end

    // Plain flop chain, no logic between stages.
    logic [BUS_WIDTH-1:0] stage [NUM_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= async;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
        bit_sync_filt_ch #(
            .FILTER_CNT(FILTER_CNT)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (stage[NUM_STAGES-1][i]),
            .sync (sync[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_bit_sync_filt.sv
module tb_bit_sync_filt;

    localparam int unsigned BW  = 4;
    localparam int unsigned NS  = 2;
    localparam int unsigned FC  = 3;
    localparam int unsigned HLEN = NS + FC - 1;

`ifdef BIT_SYNC_FILT_EDGE_EN
    localparam logic EDGE_ON = 1'b1;
`else
    localparam logic EDGE_ON = 1'b0;
`endif
    localparam logic [BW-1:0] EMASK = {BW{EDGE_ON}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] async = '0;
    logic [BW-1:0] sync, rise, fall;
    logic [BW-1:0] sync2, rise2, fall2;

    always #5 clk = ~clk;

    bit_sync_filt #(
        .BUS_WIDTH (BW),
        .NUM_STAGES(NS),
        .FILTER_CNT(FC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .async(async),
        .sync (sync),
        .rise (rise),
        .fall (fall)
    );

    bit_sync_filt #(
        .BUS_WIDTH (BW),
        .NUM_STAGES(3),
        .FILTER_CNT(1)
    ) dut2 (
        .clk  (clk),
        .rst  (rst),
        .async(async),
        .sync (sync2),
        .rise (rise2),
        .fall (fall2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel's output level flips once the last FC
    // values seen at the chain output all disagree with it. hist holds the
    // async samples taken at previous edges, newest first.
    logic [BW-1:0] hist [$];
    logic [BW-1:0] m_sync = '0;
    logic [BW-1:0] m_rise = '0;
    logic [BW-1:0] m_fall = '0;

    task automatic model_edge(input logic r, input logic [BW-1:0] a);
        logic [BW-1:0] h;
        bit            all_diff;
        if (r) begin
            hist.delete();
            for (int i = 0; i < HLEN; i++) hist.push_back('0);
            m_sync = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < BW; ch++) begin
                all_diff = 1'b1;
                // chain output seen at this edge is the sample from NS edges ago
                for (int j = NS - 1; j < HLEN; j++) begin
                    h = hist[j];
                    if (h[ch] == m_sync[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_sync[ch] = ~m_sync[ch];
                    if (m_sync[ch]) m_rise[ch] = 1'b1;
                    else            m_fall[ch] = 1'b1;
                end
            end
            hist.push_front(a);
            void'(hist.pop_back());
        end
    endtask

    task automatic step(input logic r, input logic [BW-1:0] a);
        @(negedge clk);
        rst   = r;
        async = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
        chk("model_sync", sync, m_sync);
        chk("model_rise", rise, m_rise & EMASK);
        chk("model_fall", fall, m_fall & EMASK);
        chk("rise_fall_overlap", rise & fall, '0);
    endtask

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] s;
        logic [BW-1:0] r;
        logic [BW-1:0] f;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic [BW-1:0] a, s, r, f);
        vec_t v;
        v.a = a; v.s = s; v.r = r; v.f = f;
        return v;
    endfunction

    initial begin
        logic [BW-1:0] cur;

        // level on ch0 then back, glitch of 2 on ch1, then a real pulse of 3
        for (int i = 0; i < 4; i++) tbl[i] = mk(4'h1, 4'h0, 4'h0, 4'h0);
        tbl[4] = mk(4'h1, 4'h1, 4'h1, 4'h0);
        for (int i = 5; i < 9; i++) tbl[i] = mk(4'h0, 4'h1, 4'h0, 4'h0);
        tbl[9]  = mk(4'h0, 4'h0, 4'h0, 4'h1);
        tbl[10] = mk(4'h0, 4'h0, 4'h0, 4'h0);
        tbl[11] = mk(4'h2, 4'h0, 4'h0, 4'h0);
        tbl[12] = mk(4'h2, 4'h0, 4'h0, 4'h0);
        for (int i = 13; i < 18; i++) tbl[i] = mk(4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 18; i < 21; i++) tbl[i] = mk(4'h2, 4'h0, 4'h0, 4'h0);
        tbl[21] = mk(4'h0, 4'h0, 4'h0, 4'h0);
        tbl[22] = mk(4'h0, 4'h2, 4'h2, 4'h0);
        tbl[23] = mk(4'h0, 4'h2, 4'h0, 4'h0);
        tbl[24] = mk(4'h0, 4'h2, 4'h0, 4'h0);
        tbl[25] = mk(4'h0, 4'h0, 4'h0, 4'h2);
        tbl[26] = mk(4'h0, 4'h0, 4'h0, 4'h0);

        // Reset held 2 cycles with all inputs high
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF);
            chk("rst_sync", sync, 4'h0);
            chk("rst_rise", rise, 4'h0);
            chk("rst_fall", fall, 4'h0);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'hF);
            chk("post_rst_sync", sync, (i >= 4) ? 4'hF : 4'h0);
            chk("post_rst_rise", rise, (i == 4) ? EMASK : 4'h0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 4'h0);
        chk("settle_sync", sync, 4'h0);

        // Table vectors
        for (int i = 0; i < 27; i++) begin
            step(1'b0, tbl[i].a);
            chk("tbl_sync", sync, tbl[i].s);
            chk("tbl_rise", rise, tbl[i].r & EMASK);
            chk("tbl_fall", fall, tbl[i].f & EMASK);
        end

        // Reset while ch2 counter sits at FILTER_CNT-1
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h4);
            chk("midcnt_sync", sync, 4'h0);
        end
        step(1'b1, 4'h4);
        chk("midcnt_rst_sync", sync, 4'h0);
        chk("midcnt_rst_rise", rise, 4'h0);
        chk("midcnt_rst_fall", fall, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h4);
            chk("midcnt_relat_sync", sync, (i >= 4) ? 4'h4 : 4'h0);
            chk("midcnt_relat_rise", rise, (i == 4) ? (4'h4 & EMASK) : 4'h0);
        end

        // NUM_STAGES=3 / FILTER_CNT=1 instance: 3-edge latency after sampling
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0);
        chk("alt_settle", sync2, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'hA);
            chk("alt_sync", sync2, (i >= 3) ? 4'hA : 4'h0);
            chk("alt_rise", rise2, (i == 3) ? (4'hA & EMASK) : 4'h0);
            chk("alt_fall", fall2, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h0);
            chk("alt_fall_sync", sync2, (i >= 3) ? 4'h0 : 4'hA);
            chk("alt_fall_pulse", fall2, (i == 3) ? (4'hA & EMASK) : 4'h0);
        end

        // Randomized: bits toggle with ~1/3 probability, occasional reset
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < BW; ch++) begin
                if ($urandom_range(2, 0) == 0) cur[ch] = ~cur[ch];
            end
            step(($urandom_range(59, 0) == 0), cur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
